// File: rtl/bcd_div_pkg.sv
// Shared types and constants for the sequential BCD divider.
// Optional feature macro used by the divider: BCD_DIV_EARLY_EXIT_EN.
package bcd_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    FINISH
  } bcd_div_state_t;

  localparam int BCD_DIV_STEPS = 7;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int BCD_DIV_BIN_W = 7;

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combinational two-digit BCD to binary conversion (tens*10 + units).
module bcd_pair_to_bin
  import bcd_div_pkg::*;
(
  input  logic [3:0]               tens,
  input  logic [3:0]               units,
  output logic [BCD_DIV_BIN_W-1:0] bin
);

  // tens*10 built as tens*8 + tens*2 so no multiplier is inferred
  assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};

endmodule

// File: rtl/bcd_divider.sv
// Sequential BCD divider: two-digit dividend / one-digit divisor, start/busy/done handshake.
// Define BCD_DIV_EARLY_EXIT_EN to skip the divide loop when dividend < divisor.
module bcd_divider
  import bcd_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend_bcd,
  input  logic [3:0] divisor_bcd,
  output logic [7:0] quotient_bcd,
  output logic [3:0] remainder_bcd,
  output logic       busy,
  output logic       done,
  output logic       error
);

  bcd_div_state_t           state_reg;
  logic [7:0]               dvd_reg;
  logic [3:0]               dsr_reg;
  logic [BCD_DIV_BIN_W-1:0] q_reg;
  logic [3:0]               rem_reg;
  logic [2:0]               step_reg;
  logic                     err_reg;

  logic [BCD_DIV_BIN_W-1:0] dvd_bin;
  logic [11:0]              operand_nibbles;
  logic [2:0]               digit_bad;
  logic                     operand_err;

  bcd_pair_to_bin u_pair_to_bin (
    .tens  (dvd_reg[7:4]),
    .units (dvd_reg[3:0]),
    .bin   (dvd_bin)
  );

  assign operand_nibbles = {dsr_reg, dvd_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit_chk
      assign digit_bad[gi] = operand_nibbles[gi*4 +: 4] > 4'(BCD_MAX_DIGIT);
    end
  endgenerate

  assign operand_err = (|digit_bad) || (dsr_reg == 4'h0);

  // One restoring step: remainder stays below the divisor, so the shifted value fits 5 bits
  logic [4:0] shifted;
  logic [3:0] diff;
  logic       borrow;

  assign shifted = {rem_reg, q_reg[BCD_DIV_BIN_W-1]};
  assign borrow  = shifted < {1'b0, dsr_reg};
  assign diff    = 4'(shifted - {1'b0, dsr_reg});

  logic [BCD_DIV_BIN_W-1:0] q_rest;
  logic [3:0]               q_tens;

  always_comb begin
    q_rest = q_reg;
    q_tens = 4'h0;
    for (int i = 0; i < BCD_MAX_DIGIT; i++) begin
      if (q_rest >= 7'd10) begin
        q_rest = q_rest - 7'd10;
        q_tens = q_tens + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= 8'h00;
      dsr_reg       <= 4'h0;
      q_reg         <= '0;
      rem_reg       <= 4'h0;
      step_reg      <= 3'd0;
      err_reg       <= 1'b0;
      quotient_bcd  <= 8'h00;
      remainder_bcd <= 4'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg   <= dividend_bcd;
            dsr_reg   <= divisor_bcd;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (operand_err) begin
            err_reg   <= 1'b1;
            q_reg     <= '0;
            rem_reg   <= 4'h0;
            state_reg <= FINISH;
`ifdef BCD_DIV_EARLY_EXIT_EN
          end else if (dvd_bin < {3'b000, dsr_reg}) begin
            // dividend below a single digit means tens is zero and units is the remainder
            err_reg   <= 1'b0;
            q_reg     <= '0;
            rem_reg   <= dvd_reg[3:0];
            state_reg <= FINISH;
`endif
          end else begin
            err_reg   <= 1'b0;
            q_reg     <= dvd_bin;
            rem_reg   <= 4'h0;
            step_reg  <= 3'd0;
            state_reg <= DIVIDE;
          end
        end
        DIVIDE: begin
          q_reg    <= {q_reg[BCD_DIV_BIN_W-2:0], ~borrow};
          rem_reg  <= borrow ? shifted[3:0] : diff;
          step_reg <= step_reg + 3'd1;
          if (step_reg == 3'(BCD_DIV_STEPS - 1)) begin
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          quotient_bcd  <= {q_tens, q_rest[3:0]};
          remainder_bcd <= rem_reg;
          error         <= err_reg;
          done          <= 1'b1;
          busy          <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
